// File: rtl/signed_mul_sequencer_if.sv
// Request/response bundle between an operand source and signed_mul_sequencer.
// master = operand source / product consumer, slave = sequencer.
interface signed_mul_sequencer_if #(
    parameter int XW = 12,
    parameter int ZW = 24
);
    logic                 req_valid;
    logic                 req_ready;
    logic signed [XW-1:0] req_x;
    logic signed [XW-1:0] req_y;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic signed [ZW-1:0] rsp_z;
    logic                 rsp_err;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_err
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_err
    );
endinterface

// File: rtl/signed_mul_sequencer.sv
// Drives a bit-serial signed_multiplier from a parallel request/response port.
// Optional watchdog on the flag waits: define SEQ_WATCHDOG_EN.
module signed_mul_sequencer #(
    parameter int XW      = 12,
    parameter int ZW      = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    signed_mul_sequencer_if.slave bus,
    output logic                  busy,
    output logic                  x_in,
    output logic                  y_in,
    output logic                  sx,
    output logic                  sy,
    input  logic                  fx,
    input  logic                  fy,
    output logic                  mul,
    input  logic                  done,
    output logic                  sz,
    input  logic                  z_out,
    input  logic                  fz
);
    localparam int CW = $clog2((XW > ZW ? XW : ZW) + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_FULL, MUL, WAIT_DONE, UNLOAD, RESP
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   bit_cnt;
    logic [XW-1:0]   x_sr, y_sr;
    logic [ZW-1:0]   z_cap;
    logic            accept;
    logic            wd_expired;
    logic            timeout_hit;
    logic            unused_fz;

    // fz is informational only; it never steers the sequence.
    assign unused_fz = fz;

    assign accept      = (state == IDLE) && bus.req_valid && bus.req_ready;
    assign timeout_hit = ((state == WAIT_FULL) || (state == WAIT_DONE)) && (state_nxt == RESP);
    assign bus.rsp_z   = z_cap;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (accept) state_nxt = LOAD;
            LOAD:      if (bit_cnt == CW'(XW - 1)) state_nxt = WAIT_FULL;
            WAIT_FULL: if (fx && fy) state_nxt = MUL;
                       else if (wd_expired) state_nxt = RESP;
            MUL:       state_nxt = WAIT_DONE;
            WAIT_DONE: if (done) state_nxt = UNLOAD;
                       else if (wd_expired) state_nxt = RESP;
            UNLOAD:    if (bit_cnt == CW'(ZW - 1)) state_nxt = RESP;
            RESP:      if (bus.rsp_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they change only on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            z_cap         <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            x_in          <= 1'b0;
            y_in          <= 1'b0;
            sx            <= 1'b0;
            sy            <= 1'b0;
            mul           <= 1'b0;
            sz            <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.req_ready <= (state_nxt == IDLE);
            bus.rsp_valid <= (state_nxt == RESP);
            busy          <= (state_nxt != IDLE);
            sx            <= (state_nxt == LOAD);
            sy            <= (state_nxt == LOAD);
            mul           <= (state_nxt == MUL);
            sz            <= (state_nxt == UNLOAD);

            x_in <= 1'b0;
            y_in <= 1'b0;
            if (accept) begin
                x_in <= bus.req_x[0];
                y_in <= bus.req_y[0];
            end else if ((state == LOAD) && (state_nxt == LOAD)) begin
                x_in <= x_sr[0];
                y_in <= y_sr[0];
            end

            if (state != state_nxt)
                bit_cnt <= '0;
            else if ((state == LOAD) || (state == UNLOAD))
                bit_cnt <= bit_cnt + CW'(1);

            // Product arrives LSB first, so it enters at the top and walks down.
            if (state == UNLOAD)
                z_cap <= {z_out, z_cap[ZW-1:1]};
            else if (timeout_hit || ((state == RESP) && (state_nxt == IDLE)))
                z_cap <= '0;
        end
    end

    // Operand shift registers hold data only; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_sr <= bus.req_x >> 1;
            y_sr <= bus.req_y >> 1;
        end else if (state == LOAD) begin
            x_sr <= x_sr >> 1;
            y_sr <= y_sr >> 1;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WDW-1:0] wd_cnt;
    logic           rsp_err_r;

    assign wd_expired  = (wd_cnt == WDW'(TIMEOUT - 1));
    assign bus.rsp_err = rsp_err_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt    <= '0;
            rsp_err_r <= 1'b0;
        end else begin
            if (state != state_nxt)
                wd_cnt <= '0;
            else if ((state == WAIT_FULL) || (state == WAIT_DONE))
                wd_cnt <= wd_cnt + WDW'(1);

            if (timeout_hit)
                rsp_err_r <= 1'b1;
            else if (state_nxt == IDLE)
                rsp_err_r <= 1'b0;
        end
    end
`else
    assign wd_expired  = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_signed_mul_sequencer.sv
// Randomized self-checking bench for signed_mul_sequencer with a behavioural
// bit-serial multiplier; define SEQ_WATCHDOG_EN to exercise the watchdog.
module tb_signed_mul_sequencer;
    localparam int XW = 12;
    localparam int ZW = 24;
`ifdef SEQ_WATCHDOG_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    signed_mul_sequencer_if #(.XW(XW), .ZW(ZW)) bus ();
    logic busy, x_in, y_in, sx, sy, fx, fy, mul, done, sz, z_out, fz;

    signed_mul_sequencer #(.XW(XW), .ZW(ZW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy),
        .x_in(x_in), .y_in(y_in), .sx(sx), .sy(sy), .fx(fx), .fy(fy),
        .mul(mul), .done(done), .sz(sz), .z_out(z_out), .fz(fz)
    );

    // Behavioural serial multiplier: 3-cycle done delay unless forced/held.
    bit          force_flags = 1'b0;
    bit          hold_done_low = 1'b0;
    logic [11:0] mx, my;
    logic [23:0] mz;
    int          nx, ny, dcnt;
    bit          pend;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mx <= '0; my <= '0; mz <= '0; nx <= 0; ny <= 0; dcnt <= 0; pend <= 1'b0;
        end else begin
            if (sx) begin mx <= {x_in, mx[11:1]}; if (nx < 12) nx <= nx + 1; end
            if (sy) begin my <= {y_in, my[11:1]}; if (ny < 12) ny <= ny + 1; end
            if (mul) begin
                mz   <= $signed({{12{mx[11]}}, mx}) * $signed({{12{my[11]}}, my});
                pend <= 1'b1; dcnt <= 3; nx <= 0; ny <= 0;
            end else if (pend && dcnt > 0) dcnt <= dcnt - 1;
            if (sz) begin mz <= mz >> 1; pend <= 1'b0; end
        end
    end
    assign fx    = force_flags || (nx == 12);
    assign fy    = force_flags || (ny == 12);
    assign done  = force_flags || (pend && dcnt == 0 && !hold_done_low);
    assign z_out = mz[0];
    assign fz    = !pend;

    // Strobe activity counters, sampled on the active edge before update.
    int n_sx = 0, n_mul = 0, n_sz = 0;
    always @(posedge clk) begin
        if (sx)  n_sx  <= n_sx + 1;
        if (mul) n_mul <= n_mul + 1;
        if (sz)  n_sz  <= n_sz + 1;
    end

    int n_tests = 0, n_fail = 0;
    int s_sx, s_mul, s_sz;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_mul(input logic [11:0] a, input logic [11:0] b);
        int ia, ib;
        ia = $signed(a);
        ib = $signed(b);
        return 24'(ia * ib);
    endfunction

    function automatic logic [63:0] all_outs();
        return {30'b0, bus.req_ready, bus.rsp_valid, bus.rsp_z, bus.rsp_err,
                busy, x_in, y_in, sx, sy, mul, sz};
    endfunction

    task automatic start_req(input logic [11:0] x, input logic [11:0] y);
        int t = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_x = x; bus.req_y = y;
        while (!bus.req_ready && t < 2000) begin @(negedge clk); t++; end
        chk("accept_wait", {63'b0, bus.req_ready}, 64'd1);
        s_sx = n_sx; s_mul = n_mul; s_sz = n_sz;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
        chk("rsp_wait", {63'b0, bus.rsp_valid}, 64'd1);
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_drop", {63'b0, bus.rsp_valid}, 64'd0);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_op(input logic [11:0] x, input logic [11:0] y, input bit pre, input int bp,
                         input logic [23:0] exp_z);
        int lat;
        logic [23:0] z0;
        start_req(x, y);
        bus.rsp_ready = pre;
        wait_rsp(lat);
        z0 = bus.rsp_z;
        chk("prod", {40'b0, z0}, {40'b0, exp_z});
        chk("err", {63'b0, bus.rsp_err}, 64'd0);
        chk("sx_cycles", 64'(n_sx - s_sx), 64'd12);
        chk("mul_pulses", 64'(n_mul - s_mul), 64'd1);
        chk("sz_cycles", 64'(n_sz - s_sz), 64'd24);
        if (!pre) begin
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk("hold_z", {40'b0, bus.rsp_z}, {40'b0, z0});
            end
        end
        finish_rsp();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, vcount;
        logic [11:0] rx, ry;
        logic [23:0] z0;
        bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 64'd0);
        rst = 1'b1;
        #1 chk("ready_after_release", {63'b0, bus.req_ready}, 64'd0);
        @(negedge clk);
        chk("ready_first_edge", {63'b0, bus.req_ready}, 64'd1);

        do_op(12'h003, 12'h005, 1'b1, 0, 24'h00000F);
        do_op(12'hFFF, 12'h002, 1'b0, 2, 24'hFFFFFE);
        do_op(12'h800, 12'h800, 1'b1, 0, 24'h400000);

        // Backpressure with a second request pending, then back-to-back accept.
        start_req(12'h123, 12'hF0F);
        wait_rsp(lat);
        z0 = bus.rsp_z;
        chk("bp_prod", {40'b0, z0}, {40'b0, ref_mul(12'h123, 12'hF0F)});
        bus.req_valid = 1'b1; bus.req_x = 12'h7FF; bus.req_y = 12'h801;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", {63'b0, bus.rsp_valid}, 64'd1);
            chk("bp_z", {40'b0, bus.rsp_z}, {40'b0, z0});
            chk("bp_req_ready", {63'b0, bus.req_ready}, 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("b2b_rsp_drop", {63'b0, bus.rsp_valid}, 64'd0);
        chk("b2b_ready", {63'b0, bus.req_ready}, 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        chk("b2b_busy", {63'b0, busy}, 64'd1);
        wait_rsp(lat);
        chk("b2b_prod", {40'b0, bus.rsp_z}, {40'b0, ref_mul(12'h7FF, 12'h801)});
        finish_rsp();

        // Minimum latency with all multiplier flags already high.
        force_flags = 1'b1;
        start_req(12'h5A5, 12'h0C3);
        bus.rsp_ready = 1'b1;
        wait_rsp(lat);
        chk("min_latency", 64'(lat), 64'd40);
        chk("min_lat_prod", {40'b0, bus.rsp_z}, {40'b0, ref_mul(12'h5A5, 12'h0C3)});
        finish_rsp();
        force_flags = 1'b0;

        // Reset during UNLOAD bit 10: no response may follow.
        start_req(12'h321, 12'h456);
        bus.rsp_ready = 1'b1;
        lat = 0;
        while ((n_sz - s_sz) < 10 && lat < 2000) begin @(negedge clk); lat++; end
        chk("unload_reached", {63'b0, sz}, 64'd1);
        rst = 1'b0;
        #1 chk("mid_reset_outs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", {63'b0, bus.req_ready}, 64'd1);
        vcount = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) vcount++;
        end
        chk("no_rsp_after_reset", 64'(vcount), 64'd0);
        bus.rsp_ready = 1'b0;

`ifdef SEQ_WATCHDOG_EN
        hold_done_low = 1'b1;
        start_req(12'h00A, 12'h00B);
        bus.rsp_ready = 1'b1;
        wait_rsp(lat);
        chk("wd_err", {63'b0, bus.rsp_err}, 64'd1);
        chk("wd_z", {40'b0, bus.rsp_z}, 64'd0);
        chk("wd_no_sz", 64'(n_sz - s_sz), 64'd0);
        chk("wd_latency", 64'(lat), 64'(XW + 3 + TMO));
        finish_rsp();
        hold_done_low = 1'b0;
`endif

        for (int k = 0; k < 16; k++) begin
            rx = 12'($urandom);
            ry = 12'($urandom);
            do_op(rx, ry, 1'($urandom), int'($urandom_range(0, 4)), ref_mul(rx, ry));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
